root_fin_collector: RTL and testbench

- Root-side sink for all upward traffic leaving the root router through its controller port (port bit 4).
- Upward traffic is FIN_BROADCAST, FIN_COMP and READ packets sent by the 64 leaf PEs.
- Tracks per-PE completion tokens for a broadcast or compute phase and pulses a done flag once every PE has reported.
- Buffers READ responses for the root controller; flags protocol violations.

---
 rtl/root_fin_collector.sv | 176 +++++++++++++++++
 tb/tb_root_fin_collector.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/root_fin_collector.sv
// Root-side sink for upward traffic: counts per-PE FIN tokens for a broadcast or
// compute phase, buffers one READ response for the controller, flags protocol errors.

`ifndef ROUTER_INFO_WIDTH
`define ROUTER_INFO_WIDTH 3
`endif
`ifndef ROUTER_ADDR_WIDTH
`define ROUTER_ADDR_WIDTH 16
`endif
`ifndef ROUTER_INFO_CONFIG
`define ROUTER_INFO_CONFIG 3'd0
`endif
`ifndef ROUTER_INFO_CALC
`define ROUTER_INFO_CALC 3'd1
`endif
`ifndef ROUTER_INFO_BROADCAST
`define ROUTER_INFO_BROADCAST 3'd2
`endif
`ifndef ROUTER_INFO_READ
`define ROUTER_INFO_READ 3'd3
`endif
`ifndef ROUTER_INFO_FIN_BROADCAST
`define ROUTER_INFO_FIN_BROADCAST 3'd4
`endif
`ifndef ROUTER_INFO_FIN_COMP
`define ROUTER_INFO_FIN_COMP 3'd5
`endif

module root_fin_collector #(
  parameter int NUM_PE     = 64,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [`ROUTER_INFO_WIDTH-1:0] in_info,
  input  logic [`ROUTER_ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          cmd_wait_bcast,
  input  logic                          cmd_wait_comp,
  input  logic                          cmd_clear,
  output logic                          fin_bcast_done,
  output logic                          fin_comp_done,
  output logic                          busy,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [`ROUTER_ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          proto_err
);

  localparam int CW = $clog2(NUM_PE + 1);
  localparam int PW = $clog2(NUM_PE);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_BCAST = 2'd1;
  localparam logic [1:0] WAIT_COMP  = 2'd2;

  logic [1:0]                    state_q, state_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [NUM_PE-1:0]             bitmap_q, bitmap_d;
  logic                          err_q, err_d;
  logic                          bdone_q, bdone_d;
  logic                          cdone_q, cdone_d;
  logic                          rd_valid_q, rd_valid_d;
  logic [`ROUTER_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]         rd_data_q, rd_data_d;

  logic          accept;
  logic [PW-1:0] pe_id;
  logic          is_read;
  logic          fin_expected;
  logic          start_any;
  logic          start_bad;

  assign in_ready = !rd_valid_q || rd_ready;
  assign accept   = in_valid && in_ready;
  assign pe_id    = in_addr[10 +: PW];
  assign is_read  = (in_info == `ROUTER_INFO_READ);

  // FINs are judged against the registered state, so a start command in the
  // same cycle does not make a concurrent FIN legal.
  assign fin_expected = ((state_q == WAIT_BCAST) && (in_info == `ROUTER_INFO_FIN_BROADCAST)) ||
                        ((state_q == WAIT_COMP)  && (in_info == `ROUTER_INFO_FIN_COMP));

  assign start_any = cmd_wait_bcast || cmd_wait_comp;
  assign start_bad = (state_q != IDLE) || (cmd_wait_bcast && cmd_wait_comp);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    bitmap_d   = bitmap_q;
    err_d      = err_q;
    bdone_d    = 1'b0;
    cdone_d    = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;

    if (rd_ready) rd_valid_d = 1'b0;

    if (cmd_clear) begin
      // Abort: the packet of this cycle is dropped silently, READ buffer survives.
      state_d  = IDLE;
      count_d  = '0;
      bitmap_d = '0;
      err_d    = 1'b0;
    end else begin
      if (accept) begin
        if (is_read) begin
          rd_valid_d = 1'b1;
          rd_addr_d  = in_addr;
          rd_data_d  = in_data;
        end else if (fin_expected) begin
          if (bitmap_q[pe_id]) begin
            err_d = 1'b1;
          end else begin
            bitmap_d[pe_id] = 1'b1;
            count_d         = count_q + 1'b1;
            if (count_d == CW'(NUM_PE)) begin
              bdone_d = (state_q == WAIT_BCAST);
              cdone_d = (state_q == WAIT_COMP);
              state_d = IDLE;
            end
          end
        end else begin
          err_d = 1'b1;
        end
      end

      if (start_any) begin
        if (start_bad) begin
          err_d = 1'b1;
        end else begin
          state_d  = cmd_wait_bcast ? WAIT_BCAST : WAIT_COMP;
          count_d  = '0;
          bitmap_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      bitmap_q   <= '0;
      err_q      <= 1'b0;
      bdone_q    <= 1'b0;
      cdone_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      bitmap_q   <= bitmap_d;
      err_q      <= err_d;
      bdone_q    <= bdone_d;
      cdone_q    <= cdone_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign fin_bcast_done = bdone_q;
  assign fin_comp_done  = cdone_q;
  assign busy           = (state_q != IDLE);
  assign rd_valid       = rd_valid_q;
  assign rd_addr        = rd_addr_q;
  assign rd_data        = rd_data_q;
  assign proto_err      = err_q;

endmodule

// File: tb/tb_root_fin_collector.sv
// Directed bench for root_fin_collector: FIN phases, duplicates, wrong-phase
// tokens, READ buffering/backpressure, cmd_clear and asynchronous reset.

`ifndef ROUTER_INFO_WIDTH
`define ROUTER_INFO_WIDTH 3
`endif
`ifndef ROUTER_ADDR_WIDTH
`define ROUTER_ADDR_WIDTH 16
`endif

module tb_root_fin_collector;

  localparam logic [2:0] T_CONFIG = 3'd0;
  localparam logic [2:0] T_READ   = 3'd3;
  localparam logic [2:0] T_FINB   = 3'd4;
  localparam logic [2:0] T_FINC   = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_info;
  logic [15:0] in_addr;
  logic [15:0] in_data;
  logic        cmd_wait_bcast, cmd_wait_comp, cmd_clear;
  logic        fin_bcast_done, fin_comp_done, busy;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_addr, rd_data;
  logic        proto_err;

  int checks = 0;
  int failures = 0;

  root_fin_collector #(.NUM_PE(64), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_info(in_info),
    .in_addr(in_addr), .in_data(in_data),
    .cmd_wait_bcast(cmd_wait_bcast), .cmd_wait_comp(cmd_wait_comp), .cmd_clear(cmd_clear),
    .fin_bcast_done(fin_bcast_done), .fin_comp_done(fin_comp_done), .busy(busy),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Stimulus: one packet for one cycle, returns #1 after the edge.
  task automatic send_pkt(input logic [2:0] info, input logic [15:0] addr, input logic [15:0] data);
    in_valid = 1'b1; in_info = info; in_addr = addr; in_data = data;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_fin(input logic [2:0] info, input int id);
    logic [5:0] pid;
    pid = id[5:0];
    send_pkt(info, {pid, 10'h000}, 16'h0);
  endtask

  task automatic pulse_cmd(input logic b, input logic c, input logic clr);
    cmd_wait_bcast = b; cmd_wait_comp = c; cmd_clear = clr;
    @(posedge clk); #1;
    cmd_wait_bcast = 1'b0; cmd_wait_comp = 1'b0; cmd_clear = 1'b0;
  endtask

  // Sends all 64 ids in a fixed scrambled order; done must appear only after the last.
  task automatic run_phase(input logic [2:0] info, input string tag);
    logic done;
    for (int i = 0; i < 64; i++) begin
      send_fin(info, (i * 37 + 7) % 64);
      done = (info == T_FINB) ? fin_bcast_done : fin_comp_done;
      checks++;
      if (i < 63 && done !== 1'b0) begin
        failures++; $display("FAIL %s early_done at fin %0d: got %b want 0", tag, i, done);
      end
      if (i == 63 && (done !== 1'b1 || busy !== 1'b0)) begin
        failures++; $display("FAIL %s done_after_64: done=%b busy=%b want 1/0", tag, done, busy);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (fin_bcast_done !== 1'b0 || fin_comp_done !== 1'b0) begin
      failures++; $display("FAIL %s pulse_width: bcast=%b comp=%b want 0/0", tag, fin_bcast_done, fin_comp_done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++;
    if ({in_ready, fin_bcast_done, fin_comp_done, busy, rd_valid, proto_err} !== 6'b100000 ||
        rd_addr !== 16'h0 || rd_data !== 16'h0) begin
      failures++; $display("FAIL reset_state: ready=%b bd=%b cd=%b busy=%b rv=%b err=%b want 1,0,0,0,0,0",
                           in_ready, fin_bcast_done, fin_comp_done, busy, rd_valid, proto_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_comp;
    pulse_cmd(1'b0, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL comp_busy: got %b want 1", busy); end
    run_phase(T_FINC, "full_comp");
    checks++;
    if (proto_err !== 1'b0) begin failures++; $display("FAIL comp_err: got %b want 0", proto_err); end
  endtask

  task automatic test_duplicate;
    pulse_cmd(1'b1, 1'b0, 1'b0);
    send_fin(T_FINB, 5);
    checks++;
    if (proto_err !== 1'b0) begin failures++; $display("FAIL dup_first: err=%b want 0", proto_err); end
    send_fin(T_FINB, 5);
    checks++;
    if (proto_err !== 1'b1) begin failures++; $display("FAIL dup_second: err=%b want 1", proto_err); end
    for (int i = 0; i < 64; i++) begin
      if (i != 5) begin
        send_fin(T_FINB, i);
        checks++;
        if (fin_bcast_done !== (i == 63)) begin
          failures++; $display("FAIL dup_done id %0d: got %b want %b", i, fin_bcast_done, (i == 63));
        end
      end
    end
    pulse_cmd(1'b0, 1'b0, 1'b1);
    checks++;
    if (proto_err !== 1'b0) begin failures++; $display("FAIL dup_clear: err=%b want 0", proto_err); end
  endtask

  task automatic test_wrong_phase;
    send_fin(T_FINC, 3);
    checks++;
    if (proto_err !== 1'b1 || fin_comp_done !== 1'b0) begin
      failures++; $display("FAIL idle_fin: err=%b done=%b want 1/0", proto_err, fin_comp_done);
    end
    pulse_cmd(1'b0, 1'b0, 1'b1);
    checks++;
    if (proto_err !== 1'b0) begin failures++; $display("FAIL clear_err: err=%b want 0", proto_err); end
    pulse_cmd(1'b1, 1'b0, 1'b0);
    send_fin(T_FINC, 3);
    checks++;
    if (proto_err !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL wrong_type: err=%b busy=%b want 1/1", proto_err, busy);
    end
    // Wrong-type FIN must not have counted: a full set of 64 is still required.
    run_phase(T_FINB, "after_wrong");
    pulse_cmd(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_read;
    rd_ready = 1'b0;
    send_pkt(T_READ, 16'h8C00, 16'h1234);
    checks++;
    if (rd_valid !== 1'b1 || rd_addr !== 16'h8C00 || rd_data !== 16'h1234 || in_ready !== 1'b0) begin
      failures++; $display("FAIL read_hold: rv=%b addr=%h data=%h ready=%b want 1/8c00/1234/0",
                           rd_valid, rd_addr, rd_data, in_ready);
    end
    in_valid = 1'b1; in_info = T_READ; in_addr = 16'h0400; in_data = 16'hABCD;
    @(posedge clk); #1;
    checks++;
    if (rd_data !== 16'h1234 || in_ready !== 1'b0) begin
      failures++; $display("FAIL read_stall: data=%h ready=%b want 1234/0", rd_data, in_ready);
    end
    rd_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL read_ready_comb: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_addr !== 16'h0400 || rd_data !== 16'hABCD) begin
      failures++; $display("FAIL read_overwrite: rv=%b addr=%h data=%h want 1/0400/abcd", rd_valid, rd_addr, rd_data);
    end
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b0 || proto_err !== 1'b0) begin
      failures++; $display("FAIL read_drain: rv=%b err=%b want 0/0", rd_valid, proto_err);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_bad_cmds;
    send_pkt(T_CONFIG, 16'h0000, 16'h0000);
    checks++;
    if (proto_err !== 1'b1) begin failures++; $display("FAIL config_pkt: err=%b want 1", proto_err); end
    pulse_cmd(1'b0, 1'b0, 1'b1);
    pulse_cmd(1'b1, 1'b1, 1'b0);
    checks++;
    if (proto_err !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL both_starts: err=%b busy=%b want 1/0", proto_err, busy);
    end
    pulse_cmd(1'b0, 1'b0, 1'b1);
    pulse_cmd(1'b0, 1'b1, 1'b0);
    pulse_cmd(1'b1, 1'b0, 1'b0);
    checks++;
    if (proto_err !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL start_busy: err=%b busy=%b want 1/1", proto_err, busy);
    end
    // The ignored start must leave the phase as a compute phase.
    run_phase(T_FINC, "start_busy_phase");
    pulse_cmd(1'b0, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b0 || proto_err !== 1'b0) begin
      failures++; $display("FAIL clear_idle: busy=%b err=%b want 0/0", busy, proto_err);
    end
  endtask

  task automatic test_same_cycle;
    in_valid = 1'b1; in_info = T_FINB; in_addr = 16'h0000; in_data = 16'h0;
    pulse_cmd(1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (proto_err !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL same_cycle: err=%b busy=%b want 1/1", proto_err, busy);
    end
    run_phase(T_FINB, "same_cycle_phase");
    pulse_cmd(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    pulse_cmd(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) send_fin(T_FINC, i);
    rst = 1'b1;
    #2;
    checks++;
    if ({in_ready, fin_bcast_done, fin_comp_done, busy, rd_valid, proto_err} !== 6'b100000) begin
      failures++; $display("FAIL reset_mid: ready=%b bd=%b cd=%b busy=%b rv=%b err=%b want 1,0,0,0,0,0",
                           in_ready, fin_bcast_done, fin_comp_done, busy, rd_valid, proto_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_cmd(1'b0, 1'b1, 1'b0);
    run_phase(T_FINC, "rerun_comp");
  endtask

  initial begin
    in_valid = 1'b0; in_info = '0; in_addr = '0; in_data = '0;
    cmd_wait_bcast = 1'b0; cmd_wait_comp = 1'b0; cmd_clear = 1'b0;
    rd_ready = 1'b0;
    test_reset;
    test_full_comp;
    test_duplicate;
    test_wrong_phase;
    test_read;
    test_bad_cmds;
    test_same_cycle;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
